// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and helpers for the bit-serial adder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

    // Bit-counter width; WIDTH is at least 2, so this is never zero.
    function automatic int sa_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
//------------------------------------------------------------------------------
// full_adder
// One-bit full adder cell used as the bit-slice of the serial adder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// serial_adder
// LSB-first bit-serial adder around one full_adder cell, valid/ready on both
// sides. Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in_init,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = sa_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    logic             w_fa_sum;
    logic             w_fa_c_out;
    logic [WIDTH-1:0] w_sum_next;

    full_adder u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c_in  (r_carry),
        .sum   (w_fa_sum),
        .c_out (w_fa_c_out)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign w_sum_next = {w_fa_sum, {(WIDTH-1){1'b0}}} | (r_sum_sh >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh     <= a;
                        r_b_sh     <= b;
                        r_sum_sh   <= '0;
                        r_carry    <= c_in_init;
                        r_cnt      <= '0;
`ifdef SERIAL_ADDER_OVF_EN
                        r_a_msb    <= a[WIDTH-1];
                        r_b_msb    <= b[WIDTH-1];
`endif
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sum_sh <= w_sum_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_fa_c_out;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_sum       <= w_sum_next;
                        r_c_out     <= w_fa_c_out;
`ifdef SERIAL_ADDER_OVF_EN
                        // w_fa_sum is the final sum MSB on this edge.
                        r_ovf       <= (r_a_msb == r_b_msb) && (w_fa_sum != r_a_msb);
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

`default_nettype wire
